// File: rtl/slc3_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : slc3_mem_pkg
//  Description : Shared types and widths for the SLC-3 memory controller:
//                controller state encoding and the RAM write-port bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package slc3_mem_pkg;

    localparam int C_ADDR_W = 16;
    localparam int C_DATA_W = 16;

    // Controller states, explicitly 3 bits wide
    typedef enum logic [2:0] {
        INIT    = 3'd0,
        IDLE    = 3'd1,
        RD_WAIT = 3'd2,
        WR_WAIT = 3'd3,
        DONE    = 3'd4
    } state_t;

    // One owner's view of the RAM port (address, write data, write strobe)
    typedef struct packed {
        logic [C_ADDR_W-1:0] addr;
        logic [C_DATA_W-1:0] wdata;
        logic                we;
    } ram_port_t;

endpackage
`default_nettype wire

// File: rtl/mem_init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mem_init_seq
//  Description : Post-reset image loader. Walks the init ROM address from 0
//                to INIT_WORDS-1 and, one cycle behind, writes each returned
//                word into RAM at the same address. Flags the final write and
//                holds a done flag until the next reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_init_seq
    import slc3_mem_pkg::*;
#(
    parameter int ADDR_W     = C_ADDR_W,
    parameter int DATA_W     = C_DATA_W,
    parameter int INIT_WORDS = 256
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_init_data,
    output logic [ADDR_W-1:0] o_init_addr,
    output ram_port_t         o_wr_port,
    output logic              o_last,
    output logic              o_done
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(INIT_WORDS - 1);
    localparam logic [ADDR_W-1:0] C_ONE       = ADDR_W'(1);

    logic [ADDR_W-1:0] r_addr;
    logic              r_issue;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_wr_we;
    logic              r_done;
    logic              w_last;

    // The final write is the one cycle where a write is pending but no
    // further ROM address is being issued.
    assign w_last = r_wr_we & ~r_issue;

    // ROM address walk plus a one-stage delay to line address up with ROM data
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_addr    <= '0;
            r_issue   <= 1'b1;
            r_wr_addr <= '0;
            r_wr_we   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_wr_we   <= r_issue;
            r_wr_addr <= r_addr;
            if (r_issue) begin
                if (r_addr == C_LAST_ADDR) begin
                    r_issue <= 1'b0;
                end else begin
                    r_addr <= r_addr + C_ONE;
                end
            end
            if (w_last) begin
                r_done <= 1'b1;
            end
        end
    end

    // ROM data is already registered inside the ROM, so it is passed straight
    // through; it is gated to zero outside write cycles so the port idles at 0.
    assign o_init_addr     = r_addr;
    assign o_wr_port.addr  = r_wr_addr;
    assign o_wr_port.wdata = r_wr_we ? i_init_data : '0;
    assign o_wr_port.we    = r_wr_we;
    assign o_last          = w_last;
    assign o_done          = r_done;

endmodule
`default_nettype wire

// File: rtl/slc3_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : slc3_mem_ctrl
//  Description : SLC-3 CPU memory controller. Loads a program image from the
//                init ROM after every reset, then serves active-low OE/WE
//                requests against a synchronous RAM with fixed wait states,
//                returning registered read data and a one-cycle Ready pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module slc3_mem_ctrl
    import slc3_mem_pkg::*;
#(
    parameter int ADDR_W      = C_ADDR_W,
    parameter int DATA_W      = C_DATA_W,
    parameter int WAIT_STATES = 2,
    parameter int INIT_WORDS  = 256
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic              OE,
    input  logic              WE,
    input  logic [DATA_W-1:0] Data_to_SRAM,
    output logic [DATA_W-1:0] Data_from_SRAM,
    output logic              Ready,
    output logic              Init_Done,
    output logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int                 C_CNT_W    = $clog2(WAIT_STATES + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(WAIT_STATES);

    state_t              r_state;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0]   r_cap_addr;
    ram_port_t           r_cpu_port;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_ready;

    ram_port_t           w_init_port;
    ram_port_t           w_ram_port;
    logic                w_init_last;
    logic                w_init_done;
    logic                w_start_wr;
    logic                w_start_rd;

    mem_init_seq #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .INIT_WORDS (INIT_WORDS)
    ) u_init_seq (
        .i_clk       (Clk),
        .i_rst_n     (Reset),
        .i_init_data (init_data),
        .o_init_addr (init_addr),
        .o_wr_port   (w_init_port),
        .o_last      (w_init_last),
        .o_done      (w_init_done)
    );

    // Write beats read when both are requested. From DONE only a read to a
    // new address may restart; a write must come back through IDLE so one WE
    // assertion can never produce two writes.
    assign w_start_wr = (r_state == IDLE) && !WE;
    assign w_start_rd = ((r_state == IDLE) && WE && !OE) ||
                        ((r_state == DONE) && WE && !OE && (ADDR != r_cap_addr));

    // Controller FSM with registered RAM-side and CPU-side outputs
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state    <= INIT;
            r_cnt      <= '0;
            r_cap_addr <= '0;
            r_cpu_port <= '0;
            r_rd_data  <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_ready       <= 1'b0;
            r_cpu_port.we <= 1'b0;
            if (w_start_wr) begin
                r_state          <= WR_WAIT;
                r_cap_addr       <= ADDR;
                r_cnt            <= C_CNT_ONE;
                r_cpu_port.addr  <= ADDR;
                r_cpu_port.wdata <= Data_to_SRAM;
                r_cpu_port.we    <= 1'b1;
            end else if (w_start_rd) begin
                r_state         <= RD_WAIT;
                r_cap_addr      <= ADDR;
                r_cnt           <= C_CNT_ONE;
                r_cpu_port.addr <= ADDR;
            end else begin
                case (r_state)
                    INIT: begin
                        if (w_init_last) begin
                            r_state <= IDLE;
                        end
                    end
                    RD_WAIT, WR_WAIT: begin
                        if (r_cnt == C_CNT_LAST) begin
                            r_ready <= 1'b1;
                            r_state <= DONE;
                            if (r_state == RD_WAIT) begin
                                r_rd_data <= ram_rdata;
                            end
                        end else begin
                            r_cnt <= r_cnt + C_CNT_ONE;
                        end
                    end
                    DONE: begin
                        if (OE && WE) begin
                            r_state <= IDLE;
                        end
                    end
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= INIT;
                    end
                endcase
            end
        end
    end

    // RAM port belongs to the image loader during INIT, otherwise to the CPU
    always_comb begin
        w_ram_port = r_cpu_port;
        if (r_state == INIT) begin
            w_ram_port = w_init_port;
        end
    end

    assign ram_addr       = w_ram_port.addr;
    assign ram_wdata      = w_ram_port.wdata;
    assign ram_we         = w_ram_port.we;
    assign Data_from_SRAM = r_rd_data;
    assign Ready          = r_ready;
    assign Init_Done      = w_init_done;

endmodule
`default_nettype wire

// File: tb/tb_slc3_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slc3_mem_ctrl
//  Description : Self-checking bench for slc3_mem_ctrl with a 4-word init
//                image, a registered init ROM, a synchronous RAM and a
//                cycle-level reference model of the controller behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_slc3_mem_ctrl;

    localparam int N = 4;   // init image size
    localparam int W = 2;   // wait states

    logic        clk;
    logic        Reset;
    logic [15:0] ADDR;
    logic        OE;
    logic        WE;
    logic [15:0] Data_to_SRAM;
    logic [15:0] Data_from_SRAM;
    logic        Ready;
    logic        Init_Done;
    logic [15:0] init_addr;
    logic [15:0] init_data;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;

    int errors = 0;
    int checks = 0;

    slc3_mem_ctrl #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .WAIT_STATES (W),
        .INIT_WORDS  (N)
    ) dut (
        .Clk            (clk),
        .Reset          (Reset),
        .ADDR           (ADDR),
        .OE             (OE),
        .WE             (WE),
        .Data_to_SRAM   (Data_to_SRAM),
        .Data_from_SRAM (Data_from_SRAM),
        .Ready          (Ready),
        .Init_Done      (Init_Done),
        .init_addr      (init_addr),
        .init_data      (init_data),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_we         (ram_we),
        .ram_rdata      (ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] prefill(input int a);
        return 16'(a) ^ 16'h5A5A;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Init ROM: word i holds 0x3000+i, one cycle of read latency
    always @(posedge clk) init_data <= 16'h3000 + init_addr;

    // Synchronous RAM environment
    logic [15:0] ram [0:65535];
    initial begin : ram_model
        for (int i = 0; i < 65536; i++) ram[i] = prefill(i);
        forever begin
            @(posedge clk);
            if (ram_we) ram[ram_addr] <= ram_wdata;
            ram_rdata <= ram[ram_addr];
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] mm [0:65535];
    bit          m_valid = 1'b0;
    bit          in_init;
    int          icyc;
    int          left;
    bit          settled;
    bit          acc_wr;
    logic [15:0] acc_addr;
    logic        e_ready, e_done, e_we;
    logic [15:0] e_data, e_addr, e_wdata, e_init_addr;
    bit          chk_addr, chk_wd, chk_ia;

    function automatic void accept(input bit wr);
        acc_wr   = wr;
        acc_addr = ADDR;
        left     = W;
        settled  = 1'b0;
        e_addr   = ADDR;
        chk_addr = 1'b1;
        if (wr) begin
            e_we       = 1'b1;
            e_wdata    = Data_to_SRAM;
            chk_wd     = 1'b1;
            mm[ADDR]   = Data_to_SRAM;
        end
    endfunction

    initial begin : model
        for (int i = 0; i < 65536; i++) mm[i] = prefill(i);
        forever begin
            @(posedge clk);
            if (!Reset) begin
                m_valid     = 1'b1;
                in_init     = 1'b1;
                icyc        = 0;
                left        = 0;
                settled     = 1'b0;
                e_ready     = 1'b0;
                e_done      = 1'b0;
                e_we        = 1'b0;
                e_data      = 16'h0;
                e_addr      = 16'h0;
                e_wdata     = 16'h0;
                e_init_addr = 16'h0;
                chk_addr    = 1'b1;
                chk_wd      = 1'b1;
                chk_ia      = 1'b1;
            end else if (in_init) begin
                icyc++;
                e_ready     = 1'b0;
                e_we        = (icyc >= 1) && (icyc <= N);
                e_addr      = 16'(icyc - 1);
                e_wdata     = 16'(16'h3000 + icyc - 1);
                chk_addr    = e_we;
                chk_wd      = e_we;
                if (e_we) mm[e_addr] = e_wdata;
                chk_ia      = (icyc < N);
                e_init_addr = 16'(icyc);
                e_done      = (icyc >= N + 1);
                if (icyc == N + 1) in_init = 1'b0;
            end else begin
                e_ready  = 1'b0;
                e_we     = 1'b0;
                chk_addr = 1'b0;
                chk_wd   = 1'b0;
                chk_ia   = 1'b0;
                if (left > 0) begin
                    left--;
                    if (left == 0) begin
                        e_ready = 1'b1;
                        settled = 1'b1;
                        if (!acc_wr) e_data = mm[acc_addr];
                    end
                end else if (!settled) begin
                    if (!WE) accept(1'b1);
                    else if (!OE) accept(1'b0);
                end else if (OE && WE) begin
                    settled = 1'b0;
                end else if (!OE && WE && (ADDR != acc_addr)) begin
                    accept(1'b0);
                end
            end
        end
    end

    // Every-cycle comparison against the model
    initial begin : compare
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("ready", Ready, e_ready);
                check("rd_data", Data_from_SRAM, e_data);
                check("init_done", Init_Done, e_done);
                check("ram_we", ram_we, e_we);
                if (chk_addr) check("ram_addr", ram_addr, e_addr);
                if (chk_wd)   check("ram_wdata", ram_wdata, e_wdata);
                if (chk_ia)   check("init_addr", init_addr, e_init_addr);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_init(input string nm);
        int n;
        n = 0;
        while (!Init_Done && n < 20) begin
            tick();
            n++;
        end
        check({nm, "_latency"}, n, 5);
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!Ready && n < 10);
        check({nm, "_latency"}, n, 3);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [15:0] expv, input string nm);
        ADDR = a;
        OE   = 1'b0;
        wait_ready(nm);
        check({nm, "_data"}, Data_from_SRAM, expv);
        OE = 1'b1;
        tick();
        check({nm, "_hold"}, Data_from_SRAM, expv);
    endtask

    initial begin : stim
        int pulses;
        Reset        = 1'b0;
        OE           = 1'b1;
        WE           = 1'b1;
        ADDR         = 16'h0;
        Data_to_SRAM = 16'h0;
        repeat (3) tick();
        check("rst_ready", Ready, 0);
        check("rst_data", Data_from_SRAM, 0);
        check("rst_init_done", Init_Done, 0);
        check("rst_init_addr", init_addr, 0);
        Reset = 1'b1;
        wait_init("init1");
        check("ram0", ram[0], 16'h3000);
        check("ram1", ram[1], 16'h3001);
        check("ram2", ram[2], 16'h3002);
        check("ram3", ram[3], 16'h3003);

        do_read(16'h0002, 16'h3002, "rd2");

        ADDR         = 16'h0010;
        Data_to_SRAM = 16'hBEEF;
        WE           = 1'b0;
        pulses       = 0;
        repeat (6) begin
            tick();
            if (ram_we && ram_addr == 16'h0010) pulses++;
        end
        check("wr_pulses", pulses, 1);
        WE = 1'b1;
        tick();
        do_read(16'h0010, 16'hBEEF, "rd10");

        ADDR         = 16'h0003;
        Data_to_SRAM = 16'h1234;
        OE           = 1'b0;
        WE           = 1'b0;
        wait_ready("both");
        check("both_data_kept", Data_from_SRAM, 16'hBEEF);
        OE = 1'b1;
        WE = 1'b1;
        tick();
        check("both_ram3", ram[3], 16'h1234);
        do_read(16'h0003, 16'h1234, "rd3");

        ADDR = 16'h0001;
        OE   = 1'b0;
        wait_ready("chg1");
        check("chg1_data", Data_from_SRAM, 16'h3001);
        ADDR = 16'h0002;
        wait_ready("chg2");
        check("chg2_data", Data_from_SRAM, 16'h3002);
        OE = 1'b1;
        tick();

        ADDR = 16'h0001;
        OE   = 1'b0;
        tick();
        Reset = 1'b0;
        tick();
        check("mid_rst_ready", Ready, 0);
        check("mid_rst_data", Data_from_SRAM, 0);
        check("mid_rst_init_done", Init_Done, 0);
        check("mid_rst_init_addr", init_addr, 0);
        OE = 1'b1;
        tick();
        Reset = 1'b1;
        wait_init("init2");
        do_read(16'h0000, 16'h3000, "rd0");
        do_read(16'h0010, 16'hBEEF, "rd10_kept");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
